ticket_dispatch: RTL and testbench
==================================

# ticket_dispatch

Upstream queue and dispatch stage of the response system. It issues sequential ticket numbers on a customer button press and keeps a count of waiting customers. It watches the five counter busy flags and calls the oldest waiting number to the lowest-lettered free counter. Its `counter_call`/`number_call` outputs drive the `service` block directly, and `service`'s `counterA`..`counterE` outputs feed back into this block.

## Interface
- `MAX_WAIT`, 16: maximum number of waiting (issued, not yet called) tickets. Legal range 1..62.

- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: reset. Asynchronous and active-low: `rst`=0 resets immediately, independent of `clk`.
- `take_ticket` in 1: customer button, level. A ticket is requested on each 0→1 transition sampled on `clk`.
- `counterA`..`counterE` in 1 each: counter busy flags from `service` (0 free, 1 busy).
- `counter_call` out 3: counter being called. 0 = none, 1 = A, 2 = B, 3 = C, 4 = D, 5 = E. Codes 6 and 7 are never driven.
- `number_call` out 6: ticket number being called. Valid only while `counter_call`≠0.
- `ticket_number` out 6: last ticket issued. 0 = none issued since reset.
- `waiting_count` out 6: tickets issued but not yet called.
- `queue_full` out 1: 1 when `waiting_count`==`MAX_WAIT`.

## Operation
- All outputs are registered.
- Reset values: `counter_call`=0, `number_call`=0, `ticket_number`=0, `waiting_count`=0, `queue_full`=0. Internal state resets to: `next_issue`=1, `next_call`=1, `take_prev`=0, FSM=IDLE.
- Edge detect: `take_prev` is a registered copy of `take_ticket`. `take_rise`=`take_ticket` & ~`take_prev`. Holding the button issues exactly one ticket.
- Issue: on `take_rise` with pre-edge `waiting_count`<`MAX_WAIT`:
  - `ticket_number`←`next_issue`;
  - `next_issue` increments;
  - waiting count increments.
- Reject: on `take_rise` with pre-edge `waiting_count`==`MAX_WAIT`, the press is dropped. `ticket_number` and `next_issue` are unchanged. Fullness is judged on the pre-edge count even if a call happens on the same edge.
- Number wrap: ticket numbers run 1..63, then back to 1. Both `next_issue` and `next_call` use this wrap; 0 is never issued or called.
- Free-counter select: `sel` is the lowest-lettered counter whose busy flag is 0 (A highest priority, E lowest). There is no candidate when all five flags are 1.
- FSM states: IDLE, CALL, WAIT.
  - IDLE or WAIT, with pre-edge `waiting_count`>0 and a free counter:
    - go to CALL;
    - `counter_call`←`sel` code;
    - `number_call`←`next_call`;
    - `next_call` increments;
    - waiting count decrements.
  - IDLE or WAIT, otherwise: go to IDLE; `counter_call`←0.
  - CALL: always go to WAIT; `counter_call`←0; `number_call` holds its value.
- Why WAIT exists: `service` raises the busy flag only on the edge after it samples the call. The mandatory `counter_call`=0 cycle makes sure the next selection sees the updated flag. The same counter is never called twice for one free period.
- Simultaneous issue and call on the same edge: net `waiting_count` change is 0. `ticket_number` still updates.
- `queue_full` is recomputed from the post-edge `waiting_count`.
- `waiting_count` never exceeds `MAX_WAIT` and never underflows.

## Timing
- Button to issue: a `take_ticket` rise sampled at edge n updates `ticket_number` and `waiting_count` after edge n.
- Issue to call: with a counter free, `counter_call`≠0 after edge n+1, and `counter_call`=0 after edge n+2.
- `counter_call` is a one-cycle pulse.
- Throughput: at most one call per 2 cycles. Back-to-back calls follow the pattern CALL, WAIT, CALL.
- A counter freed by `service` (flag falls after edge m) becomes selectable at edge m+1.
- Reset asserted mid-CALL: `counter_call` clears to 0 asynchronously. No partial call survives, and numbering restarts at 1.

## Test plan
- Reset: drive `rst`=0 at an arbitrary time, including mid-CALL → all outputs 0 immediately. After release, the first ticket issued is 1.
- Single customer, all counters free: `take_ticket` rises before edge n →
  - after n: `ticket_number`=1, `waiting_count`=1;
  - after n+1: `counter_call`=1, `number_call`=1, `waiting_count`=0;
  - after n+2: `counter_call`=0.
- Priority and busy feedback: A and B busy, three tickets issued →
  - first call is C with number 1;
  - modelled `service` raises `counterC`, so the next call is D with number 2, then E with number 3;
  - no counter code repeats.
- All busy: 5 counters busy, 4 presses → `waiting_count`=4, no calls. Release `counterB` → B is called with number 1 one edge later, and `waiting_count`=3.
- Full and hold: all busy, 17 separate presses → `waiting_count`=16, `queue_full`=1, `ticket_number`=16, 17th press dropped. Holding `take_ticket` high for 10 cycles issues exactly one ticket.
- Wrap: issue and serve 63 tickets → ticket 64 is issued and called as number 1; number 0 never appears on `number_call` while `counter_call`≠0.

Source files
------------

// File: rtl/ticket_dispatch.sv
// ticket_dispatch
//   Ticket issue and dispatch stage. Issues sequential ticket numbers (1..63,
//   wrapping back to 1) on each rising edge of the customer button, counts
//   waiting customers and calls the oldest waiting number to the
//   lowest-lettered free counter. Each call is a one-cycle pulse followed by
//   a mandatory idle cycle, so the next selection sees the busy flag that
//   service raises after sampling the call.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   take_ticket    customer button (level, rising edge requests a ticket)
//   counterA..E    counter busy flags from service (1 = busy)
//   counter_call   called counter: 0 none, 1..5 = A..E
//   number_call    ticket number being called (valid while counter_call != 0)
//   ticket_number  last ticket issued, 0 = none since reset
//   waiting_count  tickets issued but not yet called
//   queue_full     waiting_count == MAX_WAIT
module ticket_dispatch #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take_ticket,
  input  logic       counterA,
  input  logic       counterB,
  input  logic       counterC,
  input  logic       counterD,
  input  logic       counterE,
  output logic [2:0] counter_call,
  output logic [5:0] number_call,
  output logic [5:0] ticket_number,
  output logic [5:0] waiting_count,
  output logic       queue_full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [5:0] MAX_W = 6'(MAX_WAIT);

  state_t     state;
  state_t     state_nx;
  logic       take_prev;
  logic       take_rise;
  logic       do_issue;
  logic       do_call;
  logic [2:0] sel;
  logic [5:0] next_issue;
  logic [5:0] next_call;
  logic [5:0] wait_nx;

  function automatic logic [5:0] wrap_inc(input logic [5:0] n);
    return (n == 6'd63) ? 6'd1 : n + 6'd1;
  endfunction

  // Lowest-lettered free counter; 0 means every counter is busy.
  always_comb begin
    sel = 3'd0;
    if      (!counterA) sel = 3'd1;
    else if (!counterB) sel = 3'd2;
    else if (!counterC) sel = 3'd3;
    else if (!counterD) sel = 3'd4;
    else if (!counterE) sel = 3'd5;
  end

  // Issue and call both look at the pre-edge count, so a press arriving
  // while full is dropped even if a call frees a slot on the same edge.
  always_comb begin
    take_rise = take_ticket & ~take_prev;
    do_issue  = take_rise && (waiting_count < MAX_W);
    do_call   = (state != CALL) && (waiting_count != 6'd0) && (sel != 3'd0);

    wait_nx = waiting_count;
    if (do_issue && !do_call)      wait_nx = waiting_count + 6'd1;
    else if (do_call && !do_issue) wait_nx = waiting_count - 6'd1;

    if (do_call)            state_nx = CALL;
    else if (state == CALL) state_nx = WAIT;
    else                    state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      take_prev     <= 1'b0;
      next_issue    <= 6'd1;
      next_call     <= 6'd1;
      counter_call  <= '0;
      number_call   <= '0;
      ticket_number <= '0;
      waiting_count <= '0;
      queue_full    <= 1'b0;
    end else begin
      state         <= state_nx;
      take_prev     <= take_ticket;
      waiting_count <= wait_nx;
      queue_full    <= (wait_nx == MAX_W);

      if (do_issue) begin
        ticket_number <= next_issue;
        next_issue    <= wrap_inc(next_issue);
      end

      if (do_call) begin
        counter_call <= sel;
        number_call  <= next_call;
        next_call    <= wrap_inc(next_call);
      end else begin
        counter_call <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ticket_dispatch.sv
module tb_ticket_dispatch;

  localparam int MAXW = 16;

  logic       clk;
  logic       rst;
  logic       take_ticket;
  logic [4:0] busy;
  logic [2:0] counter_call;
  logic [5:0] number_call;
  logic [5:0] ticket_number;
  logic [5:0] waiting_count;
  logic       queue_full;

  ticket_dispatch #(.MAX_WAIT(MAXW)) dut (
    .clk           (clk),
    .rst           (rst),
    .take_ticket   (take_ticket),
    .counterA      (busy[0]),
    .counterB      (busy[1]),
    .counterC      (busy[2]),
    .counterD      (busy[3]),
    .counterE      (busy[4]),
    .counter_call  (counter_call),
    .number_call   (number_call),
    .ticket_number (ticket_number),
    .waiting_count (waiting_count),
    .queue_full    (queue_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: waiting tickets are a plain queue of numbers.
  int q[$];
  int m_next;
  bit m_take_prev;
  bit m_cool;
  int exp_cc, exp_nc, exp_tn;

  // Service model plus test-forced busy flags.
  bit [4:0] svc_busy;
  bit [4:0] force_busy;
  int       svc_timer[5];
  int       svc_lo, svc_hi;

  int obs_cc[$];
  int obs_nc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_busy();
    busy = svc_busy | force_busy;
  endtask

  task automatic model_edge();
    bit rise;
    int pre;
    int free_idx;
    rise = take_ticket && !m_take_prev;
    pre  = q.size();
    free_idx = -1;
    for (int i = 0; i < 5; i++) begin
      if (!busy[i]) begin
        free_idx = i;
        break;
      end
    end
    if (!m_cool && pre > 0 && free_idx >= 0) begin
      exp_cc = free_idx + 1;
      exp_nc = q.pop_front();
      m_cool = 1;
    end else begin
      exp_cc = 0;
      m_cool = 0;
    end
    if (rise && pre < MAXW) begin
      q.push_back(m_next);
      exp_tn = m_next;
      m_next = (m_next == 63) ? 1 : m_next + 1;
    end
    m_take_prev = take_ticket;
  endtask

  task automatic svc_update(input int seen);
    for (int i = 0; i < 5; i++) begin
      if (svc_busy[i]) begin
        if (svc_timer[i] == 0) svc_busy[i] = 0;
        else svc_timer[i]--;
      end
    end
    if (seen != 0) begin
      svc_busy[seen-1]  = 1;
      svc_timer[seen-1] = $urandom_range(svc_hi, svc_lo);
    end
    apply_busy();
  endtask

  task automatic step();
    int seen;
    @(posedge clk);
    seen = exp_cc;
    model_edge();
    #1;
    svc_update(seen);
    check("counter_call", counter_call, exp_cc);
    check("number_call", number_call, exp_nc);
    check("ticket_number", ticket_number, exp_tn);
    check("waiting_count", waiting_count, q.size());
    check("queue_full", queue_full, q.size() == MAXW);
    if (counter_call != 0) begin
      obs_cc.push_back(counter_call);
      obs_nc.push_back(number_call);
      check("nc_nonzero", number_call != 0, 1);
    end
  endtask

  task automatic press();
    take_ticket = 1;
    step();
    take_ticket = 0;
    step();
  endtask

  // Asserts reset between clock edges and checks outputs clear at once.
  task automatic do_reset();
    #2;
    rst = 0;
    #1;
    check("rst_counter_call", counter_call, 0);
    check("rst_number_call", number_call, 0);
    check("rst_ticket_number", ticket_number, 0);
    check("rst_waiting_count", waiting_count, 0);
    check("rst_queue_full", queue_full, 0);
    q.delete();
    m_next = 1; m_take_prev = 0; m_cool = 0;
    exp_cc = 0; exp_nc = 0; exp_tn = 0;
    svc_busy = '0; force_busy = '0;
    for (int i = 0; i < 5; i++) svc_timer[i] = 0;
    take_ticket = 0;
    apply_busy();
    obs_cc.delete();
    obs_nc.delete();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 0;
    take_ticket = 0;
    busy = '0;
    svc_lo = 200; svc_hi = 200;

    // Single customer, all counters free.
    do_reset();
    svc_lo = 200; svc_hi = 200;
    take_ticket = 1;
    step();
    check("single_tn", ticket_number, 1);
    check("single_wc", waiting_count, 1);
    take_ticket = 0;
    step();
    check("single_cc", counter_call, 1);
    check("single_nc", number_call, 1);
    check("single_wc0", waiting_count, 0);
    step();
    check("single_cc_off", counter_call, 0);

    // Priority and busy feedback: A and B busy.
    do_reset();
    svc_lo = 200; svc_hi = 200;
    force_busy = 5'b00011;
    apply_busy();
    repeat (3) press();
    repeat (6) step();
    check("prio_ncalls", obs_cc.size(), 3);
    if (obs_cc.size() == 3) begin
      check("prio_cc0", obs_cc[0], 3);
      check("prio_nc0", obs_nc[0], 1);
      check("prio_cc1", obs_cc[1], 4);
      check("prio_nc1", obs_nc[1], 2);
      check("prio_cc2", obs_cc[2], 5);
      check("prio_nc2", obs_nc[2], 3);
    end

    // All busy, then free B.
    do_reset();
    force_busy = 5'b11111;
    apply_busy();
    repeat (4) press();
    check("allbusy_wc", waiting_count, 4);
    check("allbusy_ncalls", obs_cc.size(), 0);
    force_busy = 5'b11101;
    apply_busy();
    step();
    check("freeB_cc", counter_call, 2);
    check("freeB_nc", number_call, 1);
    check("freeB_wc", waiting_count, 3);

    // Hold and full.
    do_reset();
    force_busy = 5'b11111;
    apply_busy();
    take_ticket = 1;
    repeat (10) step();
    take_ticket = 0;
    step();
    check("hold_wc", waiting_count, 1);
    check("hold_tn", ticket_number, 1);
    repeat (16) press();
    check("full_wc", waiting_count, 16);
    check("full_flag", queue_full, 1);
    check("full_tn", ticket_number, 16);
    svc_lo = 0; svc_hi = 3;
    force_busy = '0;
    apply_busy();
    repeat (60) step();
    check("drain_wc", waiting_count, 0);
    check("drain_full", queue_full, 0);

    // Number wrap.
    do_reset();
    svc_lo = 0; svc_hi = 1;
    repeat (64) begin
      press();
      step();
      step();
    end
    check("wrap_tn", ticket_number, 1);
    check("wrap_ncalls", obs_nc.size(), 64);
    if (obs_nc.size() == 64) begin
      check("wrap_nc63", obs_nc[62], 63);
      check("wrap_nc64", obs_nc[63], 1);
    end

    // Randomized traffic.
    do_reset();
    svc_lo = 0; svc_hi = 6;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(2, 0) == 0) take_ticket = ~take_ticket;
      if (cyc % 50 == 0) begin
        force_busy = 5'($urandom & $urandom);
        apply_busy();
      end
      step();
    end

    // Reset mid-call, then numbering restarts.
    do_reset();
    take_ticket = 1;
    step();
    take_ticket = 0;
    step();
    check("precall_cc", counter_call, 1);
    do_reset();
    take_ticket = 1;
    step();
    check("after_rst_tn", ticket_number, 1);
    take_ticket = 0;
    step();
    check("after_rst_nc", number_call, 1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
